// File: rtl/ps2_frame_tx.sv
// Serial frame transmitter: start, LSB-first data, optional parity, stop on a clock/data pair.
// Words are queued in a small FIFO; a host inhibit aborts the current frame and it is resent whole.
module ps2_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int PARITY       = 1,
    parameter int QUARTER      = 25,
    parameter int DEPTH        = 4,
    parameter int GAP_QUARTERS = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     inhibit,
    output logic                     ser_clk,
    output logic                     ser_dat,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     frame_done,
    output logic                     aborted
);
    localparam int NBITS   = DATA_W + 2 + ((PARITY != 0) ? 1 : 0);
    localparam int AW      = $clog2(DEPTH);
    localparam int GAP_CYC = GAP_QUARTERS * QUARTER;
    localparam int QW      = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam int GW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int BW      = $clog2(NBITS);

    typedef enum logic [1:0] {IDLE, BIT, GAP} state_t;
    state_t state;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push;
    logic              pop;

    logic [NBITS-1:0]  shreg;
    logic [NBITS-1:0]  frame_word;
    logic [1:0]        quarter;
    logic [QW-1:0]     qcnt;
    logic [BW-1:0]     bits_left;
    logic [GW-1:0]     gcnt;
    logic              par_bit;
    logic              q_end;
    logic              last_cycle;

    assign in_ready   = (fill != (AW+1)'(DEPTH)) && reset_n;
    assign push       = in_valid && in_ready;
    assign q_end      = (qcnt == '0);
    // Completion wins over inhibit in the final stop-bit cycle.
    assign last_cycle = (state == BIT) && q_end && (quarter == 2'd3) && (bits_left == '0);
    assign pop        = last_cycle;
    assign busy       = (state != IDLE);

    always_comb begin
        par_bit    = (PARITY == 2) ? ^mem[rd_ptr] : ~^mem[rd_ptr];
        frame_word = '0;
        frame_word[DATA_W:1] = mem[rd_ptr];
        if (PARITY != 0)
            frame_word[NBITS-2] = par_bit;
        frame_word[NBITS-1] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            ser_clk    <= 1'b1;
            ser_dat    <= 1'b1;
            frame_done <= 1'b0;
            aborted    <= 1'b0;
            quarter    <= 2'd0;
            qcnt       <= '0;
            bits_left  <= '0;
            gcnt       <= '0;
            shreg      <= '0;
        end else begin
            frame_done <= 1'b0;
            aborted    <= 1'b0;
            case (state)
                IDLE: begin
                    if (fill != '0 && !inhibit) begin
                        state     <= BIT;
                        shreg     <= frame_word;
                        quarter   <= 2'd0;
                        qcnt      <= QW'(QUARTER - 1);
                        bits_left <= BW'(NBITS - 1);
                    end
                end
                BIT: begin
                    if (last_cycle) begin
                        state      <= GAP;
                        ser_clk    <= 1'b1;
                        frame_done <= 1'b1;
                        gcnt       <= GW'(GAP_CYC - 1);
                    end else if (inhibit) begin
                        state   <= GAP;
                        ser_clk <= 1'b1;
                        ser_dat <= 1'b1;
                        aborted <= 1'b1;
                        gcnt    <= GW'(GAP_CYC - 1);
                    end else if (!q_end) begin
                        qcnt <= qcnt - 1'b1;
                    end else begin
                        qcnt    <= QW'(QUARTER - 1);
                        quarter <= quarter + 2'd1;
                        // Quarter boundaries: data changes entering q1, clock falls entering q2.
                        case (quarter)
                            2'd0: begin
                                ser_dat <= shreg[0];
                                shreg   <= shreg >> 1;
                            end
                            2'd1: ser_clk <= 1'b0;
                            2'd3: begin
                                ser_clk   <= 1'b1;
                                bits_left <= bits_left - 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                GAP: begin
                    if (inhibit)
                        gcnt <= GW'(GAP_CYC - 1);
                    else if (gcnt == '0)
                        state <= IDLE;
                    else
                        gcnt <= gcnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_frame_tx.sv
// Directed bench for ps2_frame_tx: four parameter sets, falling-edge receivers per instance,
// hand-computed frame images and a queue scoreboard for the 16-bit random run.
module tb_ps2_frame_tx;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  din8 [3];
    logic [15:0] din_d;
    logic        vld [4];
    logic        inh [4];
    logic        rdy [4];
    logic        sclk [4];
    logic        sdat [4];
    logic        bsy [4];
    logic        fdone [4];
    logic        abrt [4];
    logic [2:0]  fillv [4];

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    ps2_frame_tx #(.QUARTER(2)) u_a (
        .clk(clk), .reset_n(reset_n), .in_data(din8[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
        .inhibit(inh[0]), .ser_clk(sclk[0]), .ser_dat(sdat[0]), .busy(bsy[0]), .fill(fillv[0]),
        .frame_done(fdone[0]), .aborted(abrt[0]));
    ps2_frame_tx #(.PARITY(2), .QUARTER(2)) u_b (
        .clk(clk), .reset_n(reset_n), .in_data(din8[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
        .inhibit(inh[1]), .ser_clk(sclk[1]), .ser_dat(sdat[1]), .busy(bsy[1]), .fill(fillv[1]),
        .frame_done(fdone[1]), .aborted(abrt[1]));
    ps2_frame_tx #(.PARITY(0), .QUARTER(2)) u_c (
        .clk(clk), .reset_n(reset_n), .in_data(din8[2]), .in_valid(vld[2]), .in_ready(rdy[2]),
        .inhibit(inh[2]), .ser_clk(sclk[2]), .ser_dat(sdat[2]), .busy(bsy[2]), .fill(fillv[2]),
        .frame_done(fdone[2]), .aborted(abrt[2]));
    ps2_frame_tx #(.DATA_W(16), .QUARTER(1)) u_d (
        .clk(clk), .reset_n(reset_n), .in_data(din_d), .in_valid(vld[3]), .in_ready(rdy[3]),
        .inhibit(inh[3]), .ser_clk(sclk[3]), .ser_dat(sdat[3]), .busy(bsy[3]), .fill(fillv[3]),
        .frame_done(fdone[3]), .aborted(abrt[3]));

    // Receivers: sample ser_dat on each ser_clk fall, file the frame image on frame_done.
    logic        pclk [4];
    logic [31:0] raw [4];
    int          nb [4] = '{default: 0};
    logic [39:0] rxbuf [4][16];
    int          rxw [4] = '{default: 0};
    int          rxr [4] = '{default: 0};
    int          run_a = 0;
    int          min_gap = 1000;
    logic        pbusy_a = 1'b0;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (pclk[i] === 1'b1 && sclk[i] === 1'b0 && nb[i] < 32) begin
                raw[i][nb[i]] = sdat[i];
                nb[i]++;
            end
            if (abrt[i] === 1'b1 || !reset_n) begin
                raw[i] = '0;
                nb[i]  = 0;
            end
            if (fdone[i] === 1'b1) begin
                rxbuf[i][rxw[i] % 16] = {8'(nb[i]), raw[i]};
                rxw[i]++;
                raw[i] = '0;
                nb[i]  = 0;
            end
            pclk[i] = sclk[i];
        end
        if (sclk[0] === 1'b1 && sdat[0] === 1'b1) run_a++;
        else run_a = 0;
        if (bsy[0] === 1'b1 && !pbusy_a && run_a < min_gap) min_gap = run_a;
        pbusy_a = (bsy[0] === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int i, input logic [15:0] d);
        @(negedge clk);
        if (i == 3) din_d = d;
        else din8[i] = d[7:0];
        vld[i] = 1'b1;
        @(negedge clk);
        vld[i] = 1'b0;
    endtask

    task automatic get_frame(input int i, input string tag, output logic [31:0] r, output int n);
        int t = 0;
        logic [39:0] e;
        while (rxw[i] == rxr[i] && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (rxw[i] == rxr[i]) begin
            chk({tag, "_timeout"}, 32'(rxw[i] - rxr[i]), 1);
            r = '0;
            n = 0;
        end else begin
            e = rxbuf[i][rxr[i] % 16];
            rxr[i]++;
            r = e[31:0];
            n = int'(e[39:32]);
        end
    endtask

    task automatic frame_latency(input int i, output int lat);
        int t = 0;
        while (!bsy[i] && t < 50) begin
            @(negedge clk);
            t++;
        end
        lat = 0;
        while (!fdone[i] && lat < 1000) begin
            @(negedge clk);
            lat++;
            if (lat == 40) chk("fill_mid_frame", 32'(fillv[i]), 1);
        end
    endtask

    task automatic wait_idle(input int i);
        int t = 0;
        while (bsy[i] && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (bsy[i]) chk("idle_timeout", 32'(bsy[i]), 0);
    endtask

    initial begin
        logic [31:0] r;
        int          n;
        int          lat;
        int          bad;
        int          got;
        int          sent;
        int          inh_cnt;
        logic [15:0] exp16;
        logic [15:0] sbq [$];
        logic [7:0]  w3 [4];
        logic        p3 [4];

        for (int i = 0; i < 4; i++) begin
            vld[i] = 1'b0;
            inh[i] = 1'b0;
        end
        for (int i = 0; i < 3; i++) din8[i] = 8'h00;
        din_d = 16'h0000;

        // Reset, with a push attempt that must be dropped.
        reset_n = 1'b0;
        vld[0]  = 1'b1;
        din8[0] = 8'hEE;
        repeat (3) @(negedge clk);
        chk("rst_ser_clk", 32'(sclk[0]), 1);
        chk("rst_ser_dat", 32'(sdat[0]), 1);
        chk("rst_fill", 32'(fillv[0]), 0);
        chk("rst_busy", 32'(bsy[0]), 0);
        chk("rst_in_ready", 32'(rdy[0]), 0);
        chk("rst_frame_done", 32'(fdone[0]), 0);
        vld[0]  = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(rdy[0]), 1);
        chk("fill_after_rst", 32'(fillv[0]), 0);

        // 0xA5, odd parity: 0,1,0,1,0,0,1,0,1,1,1
        push(0, 16'h00A5);
        chk("t1_fill_push", 32'(fillv[0]), 1);
        frame_latency(0, lat);
        chk("t1_latency", 32'(lat), 88);
        chk("t1_fill_done", 32'(fillv[0]), 0);
        get_frame(0, "t1_frame", r, n);
        chk("t1_bits", r, {21'd0, 1'b1, 1'b1, 8'hA5, 1'b0});
        chk("t1_nbits", 32'(n), 11);

        // Even parity on 0x00, and no parity on 0xFF.
        push(1, 16'h0000);
        get_frame(1, "t2_even", r, n);
        chk("t2_even_bits", r, 32'h0000_0400);
        chk("t2_even_nbits", 32'(n), 11);
        push(2, 16'h00FF);
        frame_latency(2, lat);
        chk("t2_nopar_latency", 32'(lat), 80);
        get_frame(2, "t2_nopar", r, n);
        chk("t2_nopar_bits", r, 32'h0000_03FE);
        chk("t2_nopar_nbits", 32'(n), 10);

        // Fill the FIFO; a push while full is refused, also on the popping edge.
        wait_idle(0);
        w3[0] = 8'h11; p3[0] = 1'b1;
        w3[1] = 8'h23; p3[1] = 1'b0;
        w3[2] = 8'h80; p3[2] = 1'b0;
        w3[3] = 8'hFE; p3[3] = 1'b0;
        min_gap = 1000;
        for (int i = 0; i < 4; i++) begin
            din8[0] = w3[i];
            vld[0]  = 1'b1;
            @(negedge clk);
        end
        din8[0] = 8'h55;
        chk("t3_fill_full", 32'(fillv[0]), 4);
        chk("t3_ready_full", 32'(rdy[0]), 0);
        n = 0;
        while (!fdone[0] && n < 500) begin
            @(negedge clk);
            n++;
        end
        vld[0] = 1'b0;
        chk("t3_full_pop", 32'(fillv[0]), 3);
        for (int i = 0; i < 4; i++) begin
            get_frame(0, "t3_frame", r, n);
            chk("t3_bits", r, {21'd0, 1'b1, p3[i], w3[i], 1'b0});
            chk("t3_nbits", 32'(n), 11);
        end
        wait_idle(0);
        chk("t3_fill_empty", 32'(fillv[0]), 0);
        chk("t3_gap_run", 32'(min_gap), 10);

        // Abort 0x3C during bit 5, then resend in full.
        push(0, 16'h003C);
        n = 0;
        while (nb[0] < 6 && n < 500) begin
            @(negedge clk);
            n++;
        end
        inh[0] = 1'b1;
        @(negedge clk);
        chk("t4_abort_clk", 32'(sclk[0]), 1);
        chk("t4_abort_dat", 32'(sdat[0]), 1);
        chk("t4_aborted", 32'(abrt[0]), 1);
        chk("t4_fill_kept", 32'(fillv[0]), 1);
        repeat (20) @(negedge clk);
        chk("t4_abort_pulse", 32'(abrt[0]), 0);
        chk("t4_gap_held", 32'(bsy[0]), 1);
        chk("t4_no_frame", 32'(rxw[0] - rxr[0]), 0);
        inh[0] = 1'b0;
        get_frame(0, "t4_resend", r, n);
        chk("t4_bits", r, {21'd0, 1'b1, 1'b1, 8'h3C, 1'b0});
        chk("t4_nbits", 32'(n), 11);
        wait_idle(0);
        chk("t4_fill_empty", 32'(fillv[0]), 0);

        // Inhibit in the last stop-bit cycle: the frame completes.
        push(0, 16'h005A);
        n = 0;
        while (!bsy[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (87) @(negedge clk);
        inh[0] = 1'b1;
        @(negedge clk);
        chk("t4b_done", 32'(fdone[0]), 1);
        chk("t4b_no_abort", 32'(abrt[0]), 0);
        chk("t4b_fill", 32'(fillv[0]), 0);
        repeat (30) @(negedge clk);
        chk("t4b_gap_held", 32'(bsy[0]), 1);
        inh[0] = 1'b0;
        get_frame(0, "t4b_frame", r, n);
        chk("t4b_bits", r, {21'd0, 1'b1, 1'b1, 8'h5A, 1'b0});
        wait_idle(0);

        // Reset mid-frame with three words queued.
        for (int i = 1; i <= 3; i++) begin
            din8[0] = 8'(i);
            vld[0]  = 1'b1;
            @(negedge clk);
        end
        vld[0] = 1'b0;
        n = 0;
        while (nb[0] < 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("t5_fill_before", 32'(fillv[0]), 3);
        reset_n = 1'b0;
        vld[0]  = 1'b1;
        din8[0] = 8'h77;
        @(negedge clk);
        chk("t5_clk", 32'(sclk[0]), 1);
        chk("t5_dat", 32'(sdat[0]), 1);
        chk("t5_fill", 32'(fillv[0]), 0);
        chk("t5_busy", 32'(bsy[0]), 0);
        chk("t5_no_done", 32'(fdone[0]), 0);
        chk("t5_ready", 32'(rdy[0]), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        vld[0]  = 1'b0;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (!sclk[0] || !sdat[0] || bsy[0]) bad++;
        end
        chk("t5_idle_after", 32'(bad), 0);
        chk("t5_no_frame", 32'(rxw[0] - rxr[0]), 0);
        chk("t5_fill_after", 32'(fillv[0]), 0);

        // 16-bit words with random inhibit, checked in order against the push queue.
        got = 0;
        sent = 0;
        inh_cnt = 0;
        for (int cyc = 0; cyc < 30000 && got < 12; cyc++) begin
            @(negedge clk);
            if (inh_cnt > 0) inh_cnt--;
            else if ($urandom_range(0, 149) == 0) inh_cnt = int'($urandom_range(1, 3));
            inh[3] = (inh_cnt > 0);
            if (sent < 12 && rdy[3] && $urandom_range(0, 3) == 0) begin
                din_d  = 16'($urandom);
                vld[3] = 1'b1;
                sbq.push_back(din_d);
                sent++;
            end else begin
                vld[3] = 1'b0;
            end
            if (rxw[3] != rxr[3]) begin
                r = rxbuf[3][rxr[3] % 16][31:0];
                n = int'(rxbuf[3][rxr[3] % 16][39:32]);
                rxr[3]++;
                got++;
                chk("t6_nbits", 32'(n), 19);
                chk("t6_start", 32'(r[0]), 0);
                chk("t6_stop", 32'(r[18]), 1);
                if (sbq.size() == 0) begin
                    chk("t6_unexpected_frame", 32'(sbq.size()), 1);
                end else begin
                    exp16 = sbq.pop_front();
                    chk("t6_data", 32'(r[16:1]), 32'(exp16));
                    chk("t6_parity", 32'(r[17]), 32'(~^exp16));
                end
            end
        end
        inh[3] = 1'b0;
        vld[3] = 1'b0;
        chk("t6_frames", 32'(got), 12);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
